// File: rtl/lmsm_pkg.sv
// lmsm_pkg
// Shared definitions for the load-multiple / store-multiple sequencer:
// the FSM state encoding plus the datapath widths used by the top level
// and the lowest-set-bit encoder.
package lmsm_pkg;

  localparam int ADDR_W = 16;
  localparam int NREG   = 8;
  localparam int IDX_W  = 3;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lsb_prienc.sv
// lsb_prienc
// Combinational priority encoder that picks the lowest set bit of a
// register mask, so registers are serviced from R0 upward.
// Ports:
//   i_mask  - register mask, bit i selects Ri
//   o_idx   - index of the lowest set bit (0 when the mask is empty)
//   o_valid - high when at least one bit of the mask is set
module lsb_prienc
  import lmsm_pkg::*;
(
  input  logic [NREG-1:0]  i_mask,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Scan from the top bit down so the last hit, and therefore the
  // winner, is the lowest set bit.
  always_comb begin
    o_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx = IDX_W'(i);
      end
    end
  end

  assign o_valid = |i_mask;

endmodule

// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer
// Sequences one load-multiple or store-multiple operation: walks the
// latched register mask from R0 to R7, issuing one memory access per set
// bit at consecutive addresses, then pulses done for one cycle.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   start       - begin an operation (sampled only in IDLE)
//   is_store    - 1 = store-multiple, 0 = load-multiple
//   reg_list    - register mask, bit i selects Ri
//   base_addr   - address of the first transfer
//   mem_ready   - memory accepts/completes the current access this cycle
//   busy        - high in XFER and DONE
//   mem_en      - memory access request
//   read_wbar   - 1 = read, 0 = write
//   mem_addr    - address of the current transfer
//   reg_idx     - register index of the current transfer
//   rf_wen      - register file write strobe (loads only)
//   xfer_count  - transfers completed in this operation
//   done        - one-cycle end-of-operation pulse
module lmsm_sequencer
  import lmsm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [NREG-1:0]   reg_list,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mem_ready,
  output logic              busy,
  output logic              mem_en,
  output logic              read_wbar,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [IDX_W-1:0]  reg_idx,
  output logic              rf_wen,
  output logic [CNT_W-1:0]  xfer_count,
  output logic              done
);

  state_t              r_state;
  state_t              w_nextState;
  logic [NREG-1:0]     r_mask;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_isStore;
  logic [CNT_W-1:0]    r_count;

  logic [IDX_W-1:0]    w_idx;
  logic                w_valid;
  logic [NREG-1:0]     w_maskCleared;
  logic                w_xferDone;

  lsb_prienc u_prienc (
    .i_mask  (r_mask),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  // A transfer retires only on a ready cycle in XFER; every other XFER
  // cycle is a stall where everything holds.
  assign w_xferDone    = (r_state == ST_XFER) && w_valid && mem_ready;
  assign w_maskCleared = r_mask & ~(NREG'(1) << w_idx);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Operation context: captured once at start so that input changes
  // during an operation cannot disturb it, then advanced per transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask    <= '0;
      r_addr    <= '0;
      r_isStore <= 1'b0;
      r_count   <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_mask    <= reg_list;
      r_addr    <= base_addr;
      r_isStore <= is_store;
      r_count   <= '0;
    end else if (w_xferDone) begin
      r_mask    <= w_maskCleared;
      r_addr    <= r_addr + ADDR_W'(1);
      r_count   <= r_count + CNT_W'(1);
    end
  end

  // Next-state logic; an empty mask skips XFER entirely.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nextState = (reg_list != '0) ? ST_XFER : ST_DONE;
        end
      end
      ST_XFER: begin
        if (w_xferDone && (w_maskCleared == '0)) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Output logic; rf_wen is gated by the ready cycle so a stalled load
  // writes the register file exactly once.
  always_comb begin
    busy       = 1'b0;
    mem_en     = 1'b0;
    read_wbar  = 1'b1;
    rf_wen     = 1'b0;
    done       = 1'b0;
    mem_addr   = r_addr;
    reg_idx    = w_idx;
    xfer_count = r_count;
    unique case (r_state)
      ST_XFER: begin
        busy      = 1'b1;
        mem_en    = w_valid;
        read_wbar = ~r_isStore;
        rf_wen    = w_xferDone && !r_isStore;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb_lmsm_sequencer
// Directed bench for lmsm_sequencer: a per-cycle vector table for the
// load, empty-list, stall and start-while-busy cases, plus hand-written
// sequences for the wrapping store and the mid-operation reset.
module tb_lmsm_sequencer;

  typedef struct packed {
    logic        busy;
    logic        memEn;
    logic        readWbar;
    logic [15:0] addr;
    logic [2:0]  idx;
    logic        rfWen;
    logic [3:0]  cnt;
    logic        done;
  } outs_t;

  typedef struct {
    string       name;
    logic        reset;
    logic        start;
    logic        isStore;
    logic [7:0]  regList;
    logic [15:0] base;
    logic        memReady;
    outs_t       expected;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [7:0]  reg_list;
  logic [15:0] base_addr;
  logic        mem_ready;
  logic        busy;
  logic        mem_en;
  logic        read_wbar;
  logic [15:0] mem_addr;
  logic [2:0]  reg_idx;
  logic        rf_wen;
  logic [3:0]  xfer_count;
  logic        done;

  int testsRun;
  int testsFailed;
  vec_t vecs[$];

  lmsm_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_store   (is_store),
    .reg_list   (reg_list),
    .base_addr  (base_addr),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .mem_en     (mem_en),
    .read_wbar  (read_wbar),
    .mem_addr   (mem_addr),
    .reg_idx    (reg_idx),
    .rf_wen     (rf_wen),
    .xfer_count (xfer_count),
    .done       (done)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic outs_t mk(input logic b, input logic en, input logic rw,
                               input logic [15:0] a, input logic [2:0] ix,
                               input logic wen, input logic [3:0] c,
                               input logic d);
    outs_t o;
    o.busy = b; o.memEn = en; o.readWbar = rw; o.addr = a;
    o.idx = ix; o.rfWen = wen; o.cnt = c; o.done = d;
    return o;
  endfunction

  task automatic addVec(input string n, input logic rs, input logic st,
                        input logic sto, input logic [7:0] rl,
                        input logic [15:0] ba, input logic rdy,
                        input outs_t e);
    vec_t v;
    v.name = n; v.reset = rs; v.start = st; v.isStore = sto;
    v.regList = rl; v.base = ba; v.memReady = rdy; v.expected = e;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs away from the rising edge.
  task automatic applyStimulus(input logic rs, input logic st, input logic sto,
                               input logic [7:0] rl, input logic [15:0] ba,
                               input logic rdy);
    @(negedge clk);
    reset     = rs;
    start     = st;
    is_store  = sto;
    reg_list  = rl;
    base_addr = ba;
    mem_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string n, input outs_t e);
    outs_t act;
    act = mk(busy, mem_en, read_wbar, mem_addr, reg_idx, rf_wen, xfer_count, done);
    testsRun++;
    if (act !== e) begin
      testsFailed++;
      $display("[TB] FAIL %s: got busy=%b en=%b rw=%b addr=%h idx=%0d rfw=%b cnt=%0d done=%b, expected busy=%b en=%b rw=%b addr=%h idx=%0d rfw=%b cnt=%0d done=%b",
               n, act.busy, act.memEn, act.readWbar, act.addr, act.idx, act.rfWen, act.cnt, act.done,
               e.busy, e.memEn, e.readWbar, e.addr, e.idx, e.rfWen, e.cnt, e.done);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;

    // Per-cycle vectors: inputs for the cycle, outputs expected during it.
    addVec("rst_idle", 0, 0, 0, 8'h00, 16'h0000, 0, mk(0,0,1,16'h0000,0,0,0,0));
    // Load R0,R2,R7 from 0x0040
    addVec("ld_start", 0, 1, 0, 8'h85, 16'h0040, 1, mk(0,0,1,16'h0000,0,0,0,0));
    addVec("ld_x0",    0, 0, 0, 8'h00, 16'h0000, 1, mk(1,1,1,16'h0040,0,1,0,0));
    addVec("ld_x1",    0, 0, 0, 8'h00, 16'h0000, 1, mk(1,1,1,16'h0041,2,1,1,0));
    addVec("ld_x2",    0, 0, 0, 8'h00, 16'h0000, 1, mk(1,1,1,16'h0042,7,1,2,0));
    addVec("ld_done",  0, 0, 0, 8'h00, 16'h0000, 1, mk(1,0,1,16'h0043,0,0,3,1));
    addVec("ld_idle",  0, 0, 0, 8'h00, 16'h0000, 1, mk(0,0,1,16'h0043,0,0,3,0));
    // Empty list
    addVec("em_start", 0, 1, 0, 8'h00, 16'h1234, 1, mk(0,0,1,16'h0043,0,0,3,0));
    addVec("em_done",  0, 0, 0, 8'h00, 16'h0000, 1, mk(1,0,1,16'h1234,0,0,0,1));
    addVec("em_idle",  0, 0, 0, 8'h00, 16'h0000, 1, mk(0,0,1,16'h1234,0,0,0,0));
    // Load R1 with three stall cycles
    addVec("st_start", 0, 1, 0, 8'h02, 16'h0100, 0, mk(0,0,1,16'h1234,0,0,0,0));
    addVec("st_wait1", 0, 0, 0, 8'h00, 16'h0000, 0, mk(1,1,1,16'h0100,1,0,0,0));
    addVec("st_wait2", 0, 0, 0, 8'h00, 16'h0000, 0, mk(1,1,1,16'h0100,1,0,0,0));
    addVec("st_wait3", 0, 0, 0, 8'h00, 16'h0000, 0, mk(1,1,1,16'h0100,1,0,0,0));
    addVec("st_ready", 0, 0, 0, 8'h00, 16'h0000, 1, mk(1,1,1,16'h0100,1,1,0,0));
    addVec("st_done",  0, 0, 0, 8'h00, 16'h0000, 0, mk(1,0,1,16'h0101,0,0,1,1));
    addVec("st_idle",  0, 0, 0, 8'h00, 16'h0000, 0, mk(0,0,1,16'h0101,0,0,1,0));
    // Start re-asserted with different operands while busy
    addVec("bz_start", 0, 1, 0, 8'h06, 16'h0300, 1, mk(0,0,1,16'h0101,0,0,1,0));
    addVec("bz_x0",    0, 1, 1, 8'hFF, 16'h5555, 1, mk(1,1,1,16'h0300,1,1,0,0));
    addVec("bz_x1",    0, 1, 1, 8'hFF, 16'h5555, 1, mk(1,1,1,16'h0301,2,1,1,0));
    addVec("bz_done",  0, 1, 1, 8'hFF, 16'h5555, 1, mk(1,0,1,16'h0302,0,0,2,1));
    addVec("bz_idle",  0, 0, 0, 8'h00, 16'h0000, 1, mk(0,0,1,16'h0302,0,0,2,0));

    // Initial reset
    applyStimulus(1, 0, 0, 8'h00, 16'h0000, 0);
    applyStimulus(1, 0, 0, 8'h00, 16'h0000, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].reset, vecs[i].start, vecs[i].isStore,
                    vecs[i].regList, vecs[i].base, vecs[i].memReady);
      checkOutput(vecs[i].name, vecs[i].expected);
    end

    // Store all eight registers from 0xFFFE; the address wraps past 0xFFFF.
    applyStimulus(0, 1, 1, 8'hFF, 16'hFFFE, 1);
    for (int k = 0; k < 8; k++) begin
      logic [15:0] expAddr;
      expAddr = 16'hFFFE + 16'(k);
      applyStimulus(0, 0, 0, 8'h00, 16'h0000, 1);
      checkOutput($sformatf("sto_x%0d", k), mk(1,1,0,expAddr,3'(k),0,4'(k),0));
    end
    applyStimulus(0, 0, 0, 8'h00, 16'h0000, 1);
    checkOutput("sto_done", mk(1,0,1,16'h0006,0,0,8,1));

    // Reset during the second transfer of R0..R3
    applyStimulus(0, 1, 0, 8'h0F, 16'h0010, 1);
    applyStimulus(0, 0, 0, 8'h00, 16'h0000, 1);
    checkOutput("ab_x0", mk(1,1,1,16'h0010,0,1,0,0));
    applyStimulus(1, 0, 0, 8'h00, 16'h0000, 1);
    checkOutput("ab_x1", mk(1,1,1,16'h0011,1,1,1,0));
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 0, 8'h00, 16'h0000, 1);
      checkOutput($sformatf("ab_rst%0d", k), mk(0,0,1,16'h0000,0,0,0,0));
    end

    // Fresh operation after the abort
    applyStimulus(0, 1, 0, 8'h01, 16'h0200, 1);
    applyStimulus(0, 0, 0, 8'h00, 16'h0000, 1);
    checkOutput("fr_x0", mk(1,1,1,16'h0200,0,1,0,0));
    applyStimulus(0, 0, 0, 8'h00, 16'h0000, 1);
    checkOutput("fr_done", mk(1,0,1,16'h0201,0,0,1,1));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/lmsm_sequencer.md
LMSM_SEQUENCER -- requirements
Module: lmsm_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below in this order.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin one load-multiple or store-multiple; sampled only in IDLE.
REQ-005 is_store  input  1  1 = store-multiple (register to memory); 0 = load-multiple (memory to register).
REQ-006 reg_list  input  8  register mask; bit i selects Ri.
REQ-007 base_addr  input  16  address of the first transfer.
REQ-008 mem_ready  input  1  memory accepts or completes the current access this cycle.
REQ-009 busy  output  1  high in XFER and DONE.
REQ-010 mem_en  output  1  memory access request.
REQ-011 read_wbar  output  1  1 = read, 0 = write; valid while mem_en is high.
REQ-012 mem_addr  output  16  address of the current transfer.
REQ-013 reg_idx  output  3  register file index of the current transfer.
REQ-014 rf_wen  output  1  register file write strobe, used for loads only.
REQ-015 xfer_count  output  4  number of transfers completed in the current operation (0..8).
REQ-016 done  output  1  one-cycle pulse when the operation ends.

Function
REQ-017 The FSM SHALL have three states, IDLE, XFER and DONE, and SHALL enter IDLE on reset.
REQ-018 IDLE with start=1: the block SHALL latch reg_list, base_addr and is_store, clear xfer_count, then go to XFER if reg_list≠0, else go to DONE.
REQ-019 start SHALL be ignored outside IDLE, and latched values SHALL NOT change during an operation.
REQ-020 XFER: mem_en=1, read_wbar=~is_store_latched, reg_idx=lowest set bit of the remaining mask, and mem_addr=current address.
REQ-021 XFER with mem_ready=0: all outputs and state SHALL hold; stalls are unbounded.
REQ-022 XFER with mem_ready=1: that cycle completes the transfer.
  - Load: rf_wen=1 in the same cycle.
  - Clear the serviced mask bit.
  - Address +1, 16-bit modular: 0xFFFF wraps to 0x0000.
  - xfer_count +1.
REQ-023 If the mask is zero after clearing, the next state SHALL be DONE; otherwise remain in XFER for the next set bit, with no idle cycle between transfers.
REQ-024 Registers SHALL be serviced in ascending index order: R0 first, R7 last.
REQ-025 DONE: done=1 for exactly one cycle, xfer_count holds its final value, then the FSM returns to IDLE unconditionally.
REQ-026 Latency with mem_ready held high SHALL be N+1 cycles from the start-sampling edge to done, where N = popcount(reg_list); an empty list SHALL give done one cycle after start with no memory access.
REQ-027 Outside XFER: mem_en=0, rf_wen=0, read_wbar=1.
REQ-028 rf_wen SHALL never assert during a store.

Reset
REQ-029 Reset SHALL override all other inputs, including mid-operation, and force the following on the next edge:
  - state=IDLE;
  - busy, mem_en, rf_wen, done = 0;
  - read_wbar=1;
  - mem_addr=0x0000, reg_idx=0, xfer_count=0;
  - latched mask = 0.
REQ-030 An aborted operation SHALL NOT produce done, and a start after reset SHALL begin a fresh operation.

Structure
REQ-031 The shared package lmsm_pkg SHALL hold the FSM state encoding, ADDR_W=16 and NREG=8.
REQ-032 Lowest-set-bit selection SHALL be a combinational sub-module lsb_prienc (8-bit mask in; 3-bit index and valid out), instantiated once.

Verification
REQ-033 The bench SHALL cover at least these directed scenarios:
  - Load, reg_list=8'b1000_0101, base=0x0040, mem_ready=1:
    - reg_idx 0, 2, 7 at addresses 0x0040, 0x0041, 0x0042;
    - rf_wen high on each of those cycles;
    - done 4 cycles after start;
    - xfer_count=3.
  - Store, reg_list=8'hFF, base=0xFFFE:
    - addresses 0xFFFE, 0xFFFF, 0x0000 .. 0x0005;
    - read_wbar=0 and rf_wen=0 throughout;
    - xfer_count=8.
  - reg_list=0x00 with start:
    - done pulse on the next cycle;
    - mem_en never high;
    - xfer_count=0.
  - Load, reg_list=8'h02, mem_ready low for 3 cycles:
    - reg_idx=1 and mem_addr held stable for 4 cycles;
    - a single rf_wen on the ready cycle.
  - Reset during the second transfer of reg_list=8'h0F:
    - next cycle IDLE with all outputs at reset values;
    - no done pulse.
  - start pulsed again while busy:
    - ignored, and the original sequence completes unchanged.
